// File: rtl/siso_iter_sched.sv
// Turbo-decoder iteration scheduler: loads a frame into the sample buffer, then
// replays it to one shared SISO per half-iteration (natural, then interleaved order).
module siso_iter_sched #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH_BUF  = 256,
    parameter int unsigned ITER_W     = 4,
    localparam int unsigned AW        = $clog2(DEPTH_BUF),
    localparam int unsigned CW        = AW + 1,
    localparam int unsigned IW1       = ITER_W + 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] cfg_blklen,
    input  logic [ITER_W-1:0]     cfg_n_iter,
    input  logic [DATA_WIDTH-1:0] s_axis_in_tdata,
    input  logic                  s_axis_in_tvalid,
    input  logic                  s_axis_in_tlast,
    output logic                  s_axis_in_tready,
    output logic                  buf_we,
    output logic [AW-1:0]         buf_wr_addr,
    output logic [DATA_WIDTH-1:0] buf_wr_data,
    output logic [AW-1:0]         buf_rd_addr,
    input  logic [DATA_WIDTH-1:0] buf_rd_data,
    output logic [AW-1:0]         il_idx,
    input  logic [AW-1:0]         il_addr,
    output logic [DATA_WIDTH-1:0] m_axis_siso_tdata,
    output logic                  m_axis_siso_tvalid,
    output logic                  m_axis_siso_tlast,
    input  logic                  m_axis_siso_tready,
    input  logic                  llr_tvalid,
    input  logic                  llr_tready,
    input  logic                  llr_tlast,
    output logic                  phase,
    output logic [ITER_W-1:0]     iter_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  err_len
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_WAIT, S_FIN} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           blklen, blklen_m1, ld_cnt, rd_cnt;
    logic [ITER_W-1:0]       n_iter;
    logic                    cfg_bad, in_beat, ld_last, siso_pop, llr_beat;
    logic                    err_set, iter_inc, phase_tgl, feed_enter;
    logic                    rd_issue, rd_vld, rd_last_q;
    logic [1:0]              occ;
    logic                    head_v, tail_v, head_last, tail_last;
    logic [DATA_WIDTH-1:0]   head_data, tail_data;

    assign cfg_bad   = (cfg_blklen == '0) || (cfg_blklen > DATA_WIDTH'(DEPTH_BUF));
    assign blklen_m1 = blklen - CW'(1);
    assign in_beat   = s_axis_in_tvalid & s_axis_in_tready;
    assign ld_last   = (ld_cnt == blklen_m1);
    assign siso_pop  = head_v & m_axis_siso_tready;
    assign llr_beat  = llr_tvalid & llr_tready;

    // Buffer write port follows the input stream directly
    assign buf_we      = in_beat;
    assign buf_wr_addr = ld_cnt[AW-1:0];
    assign buf_wr_data = in_beat ? s_axis_in_tdata : '0;

    assign il_idx      = rd_cnt[AW-1:0];
    assign buf_rd_addr = phase ? il_addr : rd_cnt[AW-1:0];

    assign m_axis_siso_tvalid = head_v;
    assign m_axis_siso_tdata  = head_data;
    assign m_axis_siso_tlast  = head_last;

    // Issue a read only when the skid can absorb it, counting the read in flight
    assign occ      = 2'(head_v) + 2'(tail_v) + 2'(rd_vld);
    assign rd_issue = (state == S_FEED) && (rd_cnt < blklen) && (occ < (2'd2 + 2'(siso_pop)));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        err_set    = 1'b0;
        iter_inc   = 1'b0;
        phase_tgl  = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = cfg_bad ? S_FIN : S_LOAD;
            S_LOAD: begin
                if (in_beat) begin
                    if (ld_last) begin
                        state_nxt = S_FEED;
                        err_set   = ~s_axis_in_tlast;
                    end else if (s_axis_in_tlast) begin
                        state_nxt = S_FIN;
                        err_set   = 1'b1;
                    end
                end
            end
            S_FEED: if (siso_pop && head_last) state_nxt = S_WAIT;
            S_WAIT: begin
                if (llr_beat && llr_tlast) begin
                    phase_tgl = 1'b1;
                    iter_inc  = phase;
                    if (({1'b0, iter_cnt} + IW1'(iter_inc)) < {1'b0, n_iter}) state_nxt = S_FEED;
                    else                                                       state_nxt = S_FIN;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign feed_enter = (state_nxt == S_FEED) && (state != S_FEED);

    // Configuration, status and load counter
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axis_in_tready <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_len          <= 1'b0;
            iter_cnt         <= '0;
            phase            <= 1'b0;
            blklen           <= '0;
            n_iter           <= '0;
            ld_cnt           <= '0;
        end else begin
            s_axis_in_tready <= (state_nxt == S_LOAD);
            busy             <= (state_nxt != S_IDLE);
            done             <= (state_nxt == S_FIN);
            if (state == S_IDLE && start) begin
                blklen   <= CW'(cfg_blklen);
                n_iter   <= (cfg_n_iter == '0) ? ITER_W'(1) : cfg_n_iter;
                err_len  <= cfg_bad;
                iter_cnt <= '0;
                phase    <= 1'b0;
                ld_cnt   <= '0;
            end else begin
                if (err_set)   err_len  <= 1'b1;
                if (in_beat)   ld_cnt   <= ld_cnt + CW'(1);
                if (phase_tgl) phase    <= ~phase;
                if (iter_inc)  iter_cnt <= iter_cnt + ITER_W'(1);
            end
        end
    end

    // Read address counter and one-cycle buffer latency tracking
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_cnt    <= '0;
            rd_vld    <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            if (feed_enter)    rd_cnt <= '0;
            else if (rd_issue) rd_cnt <= rd_cnt + CW'(1);
            rd_vld    <= rd_issue;
            rd_last_q <= rd_issue && (rd_cnt == blklen_m1);
        end
    end

    // Two-entry output skid: head drives the SISO stream, tail catches overflow
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_v    <= 1'b0;
            tail_v    <= 1'b0;
            head_last <= 1'b0;
            tail_last <= 1'b0;
            head_data <= '0;
            tail_data <= '0;
        end else begin
            case ({siso_pop, rd_vld})
                2'b11: begin
                    if (tail_v) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= buf_rd_data;
                        tail_last <= rd_last_q;
                    end else begin
                        head_data <= buf_rd_data;
                        head_last <= rd_last_q;
                    end
                end
                2'b10: begin
                    if (tail_v) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_v    <= 1'b0;
                    end else begin
                        head_v    <= 1'b0;
                    end
                end
                2'b01: begin
                    if (!head_v) begin
                        head_v    <= 1'b1;
                        head_data <= buf_rd_data;
                        head_last <= rd_last_q;
                    end else begin
                        tail_v    <= 1'b1;
                        tail_data <= buf_rd_data;
                        tail_last <= rd_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
